// File: rtl/fpu_pkg.sv
// Shared FP32 constants and divider FSM states used by the FDIV.S datapath.
package fpu_pkg;
  localparam int FRAC_W  = 23;
  localparam int EXP_W   = 8;
  localparam int BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, UNPACK, DIV, ROUND} div_state_t;
endpackage

// File: rtl/fp32_round_pack.sv
// Normalises the 26-bit quotient, rounds to nearest-even and packs an FP32 result.
module fp32_round_pack
  import fpu_pkg::*;
(
  input  logic              s,
  input  logic signed [9:0] e,
  input  logic [25:0]       q,
  input  logic              sticky,
  output logic [31:0]       result
);
  logic signed [10:0] exp_n, exp_r;
  logic [22:0]        frac;
  logic [23:0]        frac_r;
  logic               g, st, inc;

  always_comb begin
    if (q[25]) begin
      frac  = q[24:2];
      g     = q[1];
      st    = q[0] | sticky;
      exp_n = {e[9], e};
    end else begin
      frac  = q[23:1];
      g     = q[0];
      st    = sticky;
      exp_n = {e[9], e} - 11'sd1;
    end
    inc    = g & (st | frac[0]);
    frac_r = {1'b0, frac} + {23'd0, inc};
    // a carry out of the fraction leaves it all-zero, so only the exponent moves
    exp_r  = exp_n + $signed({10'd0, frac_r[23]});
    if (exp_r >= 11'sd255)
      result = {s, EXP_MAX, 23'd0};
    else if (exp_r <= 11'sd0)
      result = {s, 31'd0};
    else
      result = {s, exp_r[7:0], frac_r[22:0]};
  end
endmodule

// File: rtl/div_fpu_flowchart.sv
// FP32 divider: restoring mantissa division at one quotient bit per clock, start/done handshake.
module div_fpu_flowchart
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] N1,
  input  logic [31:0] N2,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);
  div_state_t state, state_nx;

  logic [31:0]       a, b;
  logic              s;
  logic signed [9:0] e;
  logic [23:0]       mb;
  logic [25:0]       rem, q;
  logic [4:0]        cnt;
  logic              spec;
  logic [31:0]       spec_val;
  logic [31:0]       packed_res;

  logic [7:0] a_exp, b_exp;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn, is_spec;
  logic [31:0] sp_val;

  assign a_exp  = a[30:23];
  assign b_exp  = b[30:23];
  assign a_zero = (a_exp == 8'd0);
  assign b_zero = (b_exp == 8'd0);
  assign a_inf  = (a_exp == EXP_MAX) && (a[22:0] == 23'd0);
  assign b_inf  = (b_exp == EXP_MAX) && (b[22:0] == 23'd0);
  assign a_nan  = (a_exp == EXP_MAX) && (a[22:0] != 23'd0);
  assign b_nan  = (b_exp == EXP_MAX) && (b[22:0] != 23'd0);
  assign sgn    = a[31] ^ b[31];

  always_comb begin
    is_spec = 1'b1;
    sp_val  = {sgn, 31'd0};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      sp_val = QNAN;
    else if (a_inf || b_zero)
      sp_val = {sgn, EXP_MAX, 23'd0};
    else if (a_zero || b_inf)
      sp_val = {sgn, 31'd0};
    else
      is_spec = 1'b0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = UNPACK;
      UNPACK:  state_nx = is_spec ? ROUND : DIV;
      DIV:     if (cnt == 5'd25) state_nx = ROUND;
      ROUND:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0; b <= '0; s <= 1'b0; e <= '0; mb <= '0;
      rem <= '0; q <= '0; cnt <= '0; spec <= 1'b0; spec_val <= '0;
      result <= '0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a <= N1;
          b <= N2;
        end
        UNPACK: begin
          s        <= sgn;
          e        <= $signed({2'b00, a_exp} - {2'b00, b_exp} + 10'd127);
          rem      <= {2'b00, 1'b1, a[22:0]};
          mb       <= {1'b1, b[22:0]};
          q        <= '0;
          cnt      <= '0;
          spec     <= is_spec;
          spec_val <= sp_val;
        end
        DIV: begin
          // remainder stays below 2*mb, so 26 bits never overflow on the shift
          if (rem >= {2'b00, mb}) begin
            q   <= {q[24:0], 1'b1};
            rem <= (rem - {2'b00, mb}) << 1;
          end else begin
            q   <= {q[24:0], 1'b0};
            rem <= rem << 1;
          end
          cnt <= cnt + 5'd1;
        end
        ROUND: begin
          result <= spec ? spec_val : packed_res;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  fp32_round_pack u_round (
    .s      (s),
    .e      (e),
    .q      (q),
    .sticky (rem != 26'd0),
    .result (packed_res)
  );
endmodule

// File: tb/tb_div_fpu_flowchart.sv
// Directed-vector bench for the FP32 divider: values, latency, specials and handshake control.
module tb_div_fpu_flowchart;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] N1, N2;
  logic [31:0] result;
  logic        busy, done;

  int vec = 0;
  int err = 0;

  div_fpu_flowchart dut (
    .clk(clk), .rst(rst), .start(start), .N1(N1), .N2(N2),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Drives one request and waits (bounded) for done; lat = edges after the start edge.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int lat);
    N1 = x; N2 = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; N1 = '0; N2 = '0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (result !== 32'h0) begin err++; $display("FAIL reset_result got %h want 00000000", result); end
    vec++; if (busy !== 1'b0)    begin err++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (done !== 1'b0)    begin err++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_values;
    logic [31:0] av [6] = '{32'h40000000, 32'h3DCCCCCD, 32'hC0C00000, 32'hBF000000, 32'hBF000000, 32'h404CCCCC};
    logic [31:0] bv [6] = '{32'h40400000, 32'h3DCCCCCD, 32'h3FC00000, 32'hC0CCCCCC, 32'h40CCCCCC, 32'h40866666};
    logic [31:0] ev [6] = '{32'h3F2AAAAB, 32'h3F800000, 32'hC0800000, 32'h3DA00001, 32'hBDA00001, 32'h3F430C31};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(av[i], bv[i], r, lat);
      vec++; if (r !== ev[i]) begin err++; $display("FAIL value[%0d] %h/%h got %h want %h", i, av[i], bv[i], r, ev[i]); end
      vec++; if (lat !== 28) begin err++; $display("FAIL latency[%0d] got %0d want 28", i, lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_specials;
    logic [31:0] av [7] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h00000000, 32'h7FC00001, 32'hFF800000, 32'h3F800000};
    logic [31:0] bv [7] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'hFF800000};
    logic [31:0] ev [7] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h80000000};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(av[i], bv[i], r, lat);
      vec++; if (r !== ev[i]) begin err++; $display("FAIL special[%0d] %h/%h got %h want %h", i, av[i], bv[i], r, ev[i]); end
      vec++; if (lat !== 2) begin err++; $display("FAIL special_latency[%0d] got %0d want 2", i, lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_range;
    logic [31:0] r;
    int lat;
    run_op(32'h7F000000, 32'h3E800000, r, lat);
    vec++; if (r !== 32'h7F800000) begin err++; $display("FAIL overflow got %h want 7f800000", r); end
    @(posedge clk); #1;
    run_op(32'h00800000, 32'h40000000, r, lat);
    vec++; if (r !== 32'h00000000) begin err++; $display("FAIL underflow got %h want 00000000", r); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_busy;
    int lat;
    int extra;
    N1 = 32'h40000000; N2 = 32'h40400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    N1 = 32'h3F800000; N2 = 32'h00000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 6;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    vec++; if (result !== 32'h3F2AAAAB) begin err++; $display("FAIL busy_ignore_result got %h want 3f2aaaab", result); end
    vec++; if (lat !== 28) begin err++; $display("FAIL busy_ignore_latency got %0d want 28", lat); end
    extra = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    vec++; if (extra !== 0) begin err++; $display("FAIL busy_ignore_queued got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    N1 = 32'h404CCCCC; N2 = 32'h40866666; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vec++; if (busy !== 1'b0)    begin err++; $display("FAIL midrst_busy got %b want 0", busy); end
    vec++; if (result !== 32'h0) begin err++; $display("FAIL midrst_result got %h want 00000000", result); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    vec++; if (pulses !== 0) begin err++; $display("FAIL midrst_done got %0d pulses want 0", pulses); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    int lat;
    run_op(32'hC0C00000, 32'h3FC00000, r, lat);
    vec++; if (r !== 32'hC0800000) begin err++; $display("FAIL b2b_first got %h want c0800000", r); end
    run_op(32'h404CCCCC, 32'h40866666, r, lat);
    vec++; if (r !== 32'h3F430C31) begin err++; $display("FAIL b2b_second got %h want 3f430c31", r); end
    vec++; if (lat !== 28) begin err++; $display("FAIL b2b_latency got %0d want 28", lat); end
    run_op(32'h00000000, 32'h00000000, r, lat);
    vec++; if (r !== 32'h7FC00000) begin err++; $display("FAIL b2b_special got %h want 7fc00000", r); end
    vec++; if (lat !== 2) begin err++; $display("FAIL b2b_special_latency got %0d want 2", lat); end
  endtask

  initial begin
    test_reset;
    test_values;
    test_specials;
    test_range;
    test_ignore_busy;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
